// File: rtl/sort_loader.sv
// sort_loader: collects eight serial WIDTH-bit elements into a parallel frame
// (a0 = first element received) and presents it with a valid/ready handshake.
// Optional feature: define SORT_LOADER_FLUSH_EN to add a 'flush' input that
// zero-pads and presents a partially filled frame.
module sort_loader #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
`ifdef SORT_LOADER_FLUSH_EN
    input  logic             flush,
`endif
    output logic             in_ready,
    output logic [WIDTH-1:0] a0,
    output logic [WIDTH-1:0] a1,
    output logic [WIDTH-1:0] a2,
    output logic [WIDTH-1:0] a3,
    output logic [WIDTH-1:0] a4,
    output logic [WIDTH-1:0] a5,
    output logic [WIDTH-1:0] a6,
    output logic [WIDTH-1:0] a7,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       count,
    output logic [7:0]       frames
);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] slots_q [8];
    logic [WIDTH-1:0] slots_d [8];
    logic [3:0]       count_q, count_d;
    logic [7:0]       frames_q, frames_d;

    // Next-state: accept into the next free slot while filling, release the
    // frame on the downstream handshake while holding.
    always_comb begin
        state_d  = state_q;
        slots_d  = slots_q;
        count_d  = count_q;
        frames_d = frames_q;
        case (state_q)
            FILL: begin
                if (in_valid) begin
                    slots_d[count_q[2:0]] = in_data;
                    count_d               = count_q + 4'd1;
                end
                if (count_d == 4'd8) begin
                    state_d = HOLD;
                end
`ifdef SORT_LOADER_FLUSH_EN
                // Flush is evaluated after the same-cycle accept, so an 8th
                // element arriving with flush is an ordinary completion.
                else if (flush && (count_d != 4'd0)) begin
                    for (int unsigned i = 0; i < 8; i++) begin
                        if (i >= 32'(count_d)) begin
                            slots_d[i[2:0]] = '0;
                        end
                    end
                    count_d = 4'd8;
                    state_d = HOLD;
                end
`endif
            end
            HOLD: begin
                if (out_ready) begin
                    state_d  = FILL;
                    count_d  = 4'd0;
                    frames_d = frames_q + 8'd1;
                end
            end
            default: state_d = FILL;
        endcase
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= FILL;
            slots_q  <= '{default: '0};
            count_q  <= '0;
            frames_q <= '0;
        end else begin
            state_q  <= state_d;
            slots_q  <= slots_d;
            count_q  <= count_d;
            frames_q <= frames_d;
        end
    end

    assign in_ready  = (state_q == FILL);
    assign out_valid = (state_q == HOLD);
    assign count     = count_q;
    assign frames    = frames_q;
    assign a0        = slots_q[0];
    assign a1        = slots_q[1];
    assign a2        = slots_q[2];
    assign a3        = slots_q[3];
    assign a4        = slots_q[4];
    assign a5        = slots_q[5];
    assign a6        = slots_q[6];
    assign a7        = slots_q[7];

endmodule

// File: tb/tb_sort_loader.sv
// Self-checking bench for sort_loader: directed vector table, async reset,
// 256-frame wrap, randomized traffic vs a queue-based reference model, and
// (with SORT_LOADER_FLUSH_EN) short-frame flush cases.
module tb_sort_loader;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic         fl = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_ready, out_valid;
    logic [W-1:0] a0, a1, a2, a3, a4, a5, a6, a7;
    logic [3:0]   count;
    logic [7:0]   frames;
    logic [W-1:0] a_w [8];

    always #5 clk = ~clk;

    sort_loader #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
`ifdef SORT_LOADER_FLUSH_EN
        .flush     (fl),
`endif
        .in_ready  (in_ready),
        .a0        (a0),
        .a1        (a1),
        .a2        (a2),
        .a3        (a3),
        .a4        (a4),
        .a5        (a5),
        .a6        (a6),
        .a7        (a7),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .frames    (frames)
    );

    assign a_w[0] = a0;
    assign a_w[1] = a1;
    assign a_w[2] = a2;
    assign a_w[3] = a3;
    assign a_w[4] = a4;
    assign a_w[5] = a5;
    assign a_w[6] = a6;
    assign a_w[7] = a7;

    int nerr = 0;
    int nchk = 0;

    // Reference model: a frame is the list of elements collected so far;
    // eight elements means the frame is on offer downstream.
    logic [W-1:0] m_q [$];
    logic [W-1:0] m_mem [8];
    logic [7:0]   m_frames;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        for (int i = 0; i < 8; i++) m_mem[i] = '0;
        m_frames = 8'd0;
    endtask

    task automatic model_step(input logic vld, input logic [W-1:0] d, input logic ordy, input logic f);
        if (m_q.size() == 8) begin
            if (ordy) begin
                m_q.delete();
                m_frames = m_frames + 8'd1;
            end
        end else begin
            if (vld) begin
                m_mem[m_q.size()] = d;
                m_q.push_back(d);
            end
            if (f && m_q.size() > 0 && m_q.size() < 8) begin
                while (m_q.size() < 8) begin
                    m_mem[m_q.size()] = '0;
                    m_q.push_back('0);
                end
            end
        end
    endtask

    task automatic check_all();
        chk("in_ready", 32'(in_ready), 32'(m_q.size() < 8));
        chk("out_valid", 32'(out_valid), 32'(m_q.size() == 8));
        chk("count", 32'(count), 32'(m_q.size()));
        chk("frames", 32'(frames), 32'(m_frames));
        for (int i = 0; i < 8; i++)
            chk($sformatf("a%0d", i), 32'(a_w[i]), 32'(m_mem[i]));
    endtask

    // Apply inputs, clock once, update the model, sample 1 ns after the edge.
    task automatic step(input logic vld, input logic [W-1:0] d, input logic ordy, input logic f);
        in_valid  = vld;
        in_data   = d;
        out_ready = ordy;
        fl        = f;
        @(posedge clk);
        model_step(vld, d, ordy, f);
        #1;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        fl        = 1'b0;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        #1;
    endtask

    typedef struct {
        logic         vld;
        logic [W-1:0] d;
        logic         ordy;
        logic         ir;
        logic         ov;
        logic [3:0]   cnt;
        logic [7:0]   fr;
    } vec_t;

    vec_t tbl [15];

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [W-1:0] e;
        int           rise_gap;

        // Directed vectors: stream 0x11..0x88, hold 5 cycles with junk
        // in_valid, consume, then start the next frame.
        for (int i = 0; i < 8; i++)
            tbl[i] = '{vld: 1'b1, d: 8'(17 * (i + 1)), ordy: 1'b1,
                       ir: (i < 7), ov: (i == 7), cnt: 4'(i + 1), fr: 8'd0};
        for (int i = 8; i < 13; i++)
            tbl[i] = '{vld: 1'b1, d: 8'hEE, ordy: 1'b0,
                       ir: 1'b0, ov: 1'b1, cnt: 4'd8, fr: 8'd0};
        tbl[13] = '{vld: 1'b0, d: 8'h00, ordy: 1'b1, ir: 1'b1, ov: 1'b0, cnt: 4'd0, fr: 8'd1};
        tbl[14] = '{vld: 1'b1, d: 8'h99, ordy: 1'b0, ir: 1'b1, ov: 1'b0, cnt: 4'd1, fr: 8'd1};

        // Reset state
        do_reset();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);

        for (int i = 0; i < 15; i++) begin
            step(tbl[i].vld, tbl[i].d, tbl[i].ordy, 1'b0);
            chk($sformatf("tbl%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].ir));
            chk($sformatf("tbl%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].ov));
            chk($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].cnt));
            chk($sformatf("tbl%0d_frames", i), 32'(frames), 32'(tbl[i].fr));
            check_all();
            if (i >= 7 && i <= 12) begin
                chk("hold_a0", 32'(a0), 32'h11);
                chk("hold_a7", 32'(a7), 32'h88);
            end
        end
        chk("next_a0", 32'(a0), 32'h99);
        chk("stale_a1", 32'(a1), 32'h22);

        // Asynchronous reset after 3 accepts, mid-cycle
        do_reset();
        step(1'b1, 8'hA1, 1'b0, 1'b0);
        step(1'b1, 8'hA2, 1'b0, 1'b0);
        step(1'b1, 8'hA3, 1'b0, 1'b0);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_count", 32'(count), 32'd0);
        chk("async_a0", 32'(a0), 32'd0);
        check_all();
        #1;
        rst_n = 1'b1;
        step(1'b1, 8'h5A, 1'b0, 1'b0);
        chk("after_rst_a0", 32'(a0), 32'h5A);
        chk("after_rst_count", 32'(count), 32'd1);
        check_all();

        // Reset during HOLD discards the frame
        step(1'b1, 8'h01, 1'b0, 1'b0);
        for (int k = 0; k < 6; k++) step(1'b1, 8'(k + 2), 1'b0, 1'b0);
        chk("pre_hold_ov", 32'(out_valid), 32'd1);
        do_reset();
        chk("hold_rst_ov", 32'(out_valid), 32'd0);

        // 256 back-to-back frames: 9-cycle period, frames wraps to 0
        do_reset();
        e = 8'd0;
        rise_gap = 0;
        for (int f = 0; f < 256; f++) begin
            for (int k = 0; k < 8; k++) begin
                step(1'b1, e, 1'b1, 1'b0);
                e = e + 8'd1;
                check_all();
            end
            chk("b2b_out_valid", 32'(out_valid), 32'd1);
            step(1'b1, 8'hFF, 1'b1, 1'b0);
            chk("b2b_count", 32'(count), 32'd0);
            chk("b2b_frames", 32'(frames), 32'((f + 1) % 256));
            rise_gap = rise_gap + 9;
        end
        chk("wrap_frames", 32'(frames), 32'd0);
        chk("wrap_cycles", 32'(rise_gap), 32'd2304);

        // Randomized traffic against the model
        do_reset();
        for (int n = 0; n < 800; n++) begin
            logic f;
            f = 1'b0;
`ifdef SORT_LOADER_FLUSH_EN
            f = ($urandom_range(0, 9) == 0);
`endif
            step($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 9) < 4, f);
            check_all();
        end

`ifdef SORT_LOADER_FLUSH_EN
        // Flush with count 0 and no accept is ignored
        do_reset();
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("fl0_count", 32'(count), 32'd0);
        chk("fl0_in_ready", 32'(in_ready), 32'd1);
        // Short frame: 05,06,07 then flush with accept 08
        step(1'b1, 8'h05, 1'b0, 1'b0);
        step(1'b1, 8'h06, 1'b0, 1'b0);
        step(1'b1, 8'h07, 1'b0, 1'b0);
        step(1'b1, 8'h08, 1'b0, 1'b1);
        chk("fl_out_valid", 32'(out_valid), 32'd1);
        chk("fl_count", 32'(count), 32'd8);
        for (int i = 0; i < 4; i++) chk($sformatf("fl_a%0d", i), 32'(a_w[i]), 32'(5 + i));
        for (int i = 4; i < 8; i++) chk($sformatf("fl_a%0d", i), 32'(a_w[i]), 32'd0);
        // Flush in HOLD is ignored
        step(1'b1, 8'h77, 1'b0, 1'b1);
        chk("fl_hold_ov", 32'(out_valid), 32'd1);
        check_all();
        step(1'b0, 8'h00, 1'b1, 1'b0);
        // 8th accept together with flush: nothing padded
        for (int k = 0; k < 7; k++) step(1'b1, 8'(8'h30 + k), 1'b0, 1'b0);
        step(1'b1, 8'h3F, 1'b0, 1'b1);
        chk("fl8_a7", 32'(a7), 32'h3F);
        chk("fl8_ov", 32'(out_valid), 32'd1);
        check_all();
`endif

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/sort_loader.md
SORT_LOADER -- requirements
Module: sort_loader

Interface
REQ-001 SHALL have parameter WIDTH, default 8, the data width of each element; all element ports are WIDTH bits.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port in_data  input  WIDTH  the serial element presented upstream.
REQ-005 SHALL have port in_valid  input  1  in_data is valid this cycle.
REQ-006 SHALL have port in_ready  output  1  the loader accepts in_data this cycle.
REQ-007 SHALL have ports a0..a7  output  WIDTH each  the parallel frame that feeds the first sorter stage; a0 is the first element received.
REQ-008 SHALL have port out_valid  output  1  a0..a7 hold a complete frame.
REQ-009 SHALL have port out_ready  input  1  the downstream stage consumes the frame this cycle.
REQ-010 SHALL have port count  output  4  the number of elements loaded in the current frame, 0..8.
REQ-011 SHALL have port frames  output  8  the count of frames consumed, wrapping modulo 256.

Function
REQ-012 SHALL implement two states: FILL (collecting elements) and HOLD (frame presented).
REQ-013 SHALL drive in_ready=1 exactly when the state is FILL, and out_valid=1 exactly when the state is HOLD; both are registered-state decodes with no combinational path from out_ready or in_valid.
REQ-014 SHALL accept an element in FILL when in_valid=1, writing in_data to slot a[count] and incrementing count.
REQ-015 SHALL leave slots not yet written in the current frame at their previous values.
REQ-016 SHALL, on acceptance of the 8th element, move to HOLD, so that out_valid=1 in the cycle after that handshake and count=8.
REQ-017 SHALL keep a0..a7 stable in HOLD until out_ready=1.
REQ-018 SHALL, when out_valid=1 and out_ready=1, return to FILL with count=0 and increment frames (0xFF wraps to 0x00); in_ready=1 from the next cycle.
REQ-019 SHALL ignore out_ready in FILL and in_valid in HOLD, with no state change, no slot write and no counter change.
REQ-020 SHALL accept at most one element per cycle, giving a minimum frame period of 9 cycles (8 accepts plus 1 HOLD cycle with out_ready=1).

Reset
REQ-021 SHALL, while rst_n=0 and independent of clk, force state FILL, a0..a7=0, count=0, frames=0, so in_ready=1 and out_valid=0.
REQ-022 SHALL discard a partial frame or an unconsumed HOLD frame on reset mid-operation; after release the next accepted element goes to a0.

Configuration
REQ-023 SHALL, when SORT_LOADER_FLUSH_EN is defined, add port flush  input  1  a request to complete a short frame.
REQ-024 SHALL, with SORT_LOADER_FLUSH_EN defined, on flush=1 in FILL with count>0 after any same-cycle accept: write 0 to all remaining slots and enter HOLD next cycle with count=8.
REQ-025 SHALL, with SORT_LOADER_FLUSH_EN defined, treat as a normal completion an accept of the 8th element in the same cycle as flush, with nothing padded.
REQ-026 SHALL, with SORT_LOADER_FLUSH_EN defined, ignore flush in HOLD, and ignore it in FILL when count=0 and no same-cycle accept occurs.
REQ-027 SHALL, without SORT_LOADER_FLUSH_EN, have no flush port, and only 8 accepted elements complete a frame.

Verification
REQ-028 SHALL cover: reset, then stream 0x11..0x88 with in_valid held high -> out_valid=1 on cycle 9, a0=0x11 and a7=0x88, in_ready=0.
REQ-029 SHALL cover: full frame with out_ready=0 for 5 cycles, then 1 -> a0..a7 unchanged for 5 cycles, in_valid ignored, frames 0->1, count=0.
REQ-030 SHALL cover: 256 back-to-back frames with out_ready held high -> frames wraps to 0x00, 9-cycle period, no dropped element.
REQ-031 SHALL cover: rst_n pulsed low after 3 accepts, asynchronously to clk -> outputs clear immediately, and the next element lands in a0.
REQ-032 SHALL cover, with SORT_LOADER_FLUSH_EN defined: 3 accepts (0x05,0x06,0x07), then flush with accept 0x08 -> a0..a3=05..08, a4..a7=0x00, out_valid=1 next cycle.
